// File: rtl/tcbm_pkg.sv
// Shared definitions for the TCBM host link: code bytes, rx tags, status encodings and FSM states.
package tcbm_pkg;

  localparam logic [7:0] CODE_CMD  = 8'h81;
  localparam logic [7:0] CODE_DATA = 8'h82;
  localparam logic [7:0] CODE_TALK = 8'h83;
  localparam logic [7:0] CODE_SEC  = 8'h84;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_CMD  = 2'b01;
  localparam logic [1:0] TAG_DATA = 2'b10;
  localparam logic [1:0] TAG_SEC  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EOI     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  typedef enum logic [3:0] {
    IDLE, CODE_ACK, CODE_REL, PAY_WAIT, RX_ACK, RX_REL, TX_WAIT, TX_ACK, TX_REL
  } state_e;

  typedef struct packed {
    logic [1:0] tag;
    logic [7:0] data;
  } rx_entry_t;

  // Tag for host-to-device codes; TAG_NONE for the talk code and invalid codes.
  function automatic logic [1:0] code_tag(input logic [7:0] code);
    case (code)
      CODE_CMD:  code_tag = TAG_CMD;
      CODE_DATA: code_tag = TAG_DATA;
      CODE_SEC:  code_tag = TAG_SEC;
      default:   code_tag = TAG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tcbm_rx_fifo.sv
// Receive FIFO of {tag, byte} entries; a push into a full FIFO succeeds when a pop happens in the same cycle.
module tcbm_rx_fifo
  import tcbm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clock,
  input  logic      _reset,
  input  logic      push_i,
  input  rx_entry_t push_data_i,
  input  logic      pop_i,
  output logic      valid_o,
  output logic      full_o,
  output rx_entry_t rd_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  rx_entry_t   mem_q [DEPTH];
  logic        empty, do_push, do_pop;

  assign empty     = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid_o   = !empty;
  assign do_pop    = pop_i && !empty;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!_reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/tcbm_link.sv
// TCBM host link device side: DAV/ACK byte handshake, code decode, rx FIFO and tx byte with timeout.
module tcbm_link
  import tcbm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned RX_DEPTH       = 4
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic [7:0] h_data_in,
  output logic [7:0] h_data_out,
  output logic       h_data_oe,
  input  logic       h_dav,
  output logic       h_ack,
  output logic [1:0] h_status,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic [1:0] rx_tag,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  output logic       err_pulse
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dav_s;
  state_e                 state_q, state_d;
  logic [7:0]             code_q, code_d, pay_q, pay_d, dout_q, dout_d;
  logic                   pend_q, pend_d, sent_q, sent_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   h_ack_q, h_ack_d, oe_q, oe_d, err_q, err_d;
  logic [1:0]             status_q, status_d;
  logic                   fifo_full, push, pay_avail;
  rx_entry_t              push_data, pop_data;

  if (SYNC_STAGES > 1) begin : g_sync_chain
    assign sync_d = {sync_q[SYNC_STAGES-2:0], h_dav};
  end else begin : g_sync_one
    assign sync_d = h_dav;
  end
  assign dav_s = sync_q[SYNC_STAGES-1];

  // A payload is available from the pins on first dav_s low, or from pay_q while stalled on a full FIFO.
  assign pay_avail = pend_q || !dav_s;
  assign push      = (state_q == PAY_WAIT) && pay_avail && (!fifo_full || (rx_valid && rx_ready));
  assign push_data = {code_tag(code_q), pend_q ? pay_q : h_data_in};
  assign tx_ready  = (state_q == TX_WAIT) && !dav_s && !sent_q;

  tcbm_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock       (clock),
    ._reset      (_reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (rx_ready),
    .valid_o     (rx_valid),
    .full_o      (fifo_full),
    .rd_data_o   (pop_data)
  );
  assign rx_data = pop_data.data;
  assign rx_tag  = pop_data.tag;

  always_ff @(posedge clock) begin
    if (!_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!dav_s) state_d = CODE_ACK;
      CODE_ACK: if (dav_s)  state_d = CODE_REL;
      CODE_REL: begin
        if (code_q == CODE_TALK)              state_d = TX_WAIT;
        else if (code_tag(code_q) != TAG_NONE) state_d = PAY_WAIT;
        else                                   state_d = IDLE;
      end
      PAY_WAIT: if (push)   state_d = RX_ACK;
      RX_ACK:   if (dav_s)  state_d = RX_REL;
      RX_REL:   state_d = IDLE;
      TX_WAIT:  if (sent_q) state_d = TX_ACK;
      TX_ACK:   if (dav_s)  state_d = TX_REL;
      TX_REL:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    code_d   = code_q;
    pay_d    = pay_q;
    pend_d   = pend_q;
    sent_d   = sent_q;
    tmo_d    = tmo_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    status_d = status_q;
    err_d    = 1'b0;
    h_ack_d  = !(state_d inside {CODE_ACK, RX_ACK, TX_ACK});
    case (state_q)
      IDLE:     if (!dav_s) code_d = h_data_in;
      CODE_ACK: if (dav_s && code_tag(code_q) == TAG_NONE && code_q != CODE_TALK) err_d = 1'b1;
      CODE_REL: begin
        pend_d = 1'b0;
        sent_d = 1'b0;
        tmo_d  = '0;
      end
      PAY_WAIT: begin
        if (push) begin
          pend_d = 1'b0;
        end else if (!dav_s && !pend_q) begin
          pay_d  = h_data_in;
          pend_d = 1'b1;
        end
      end
      // Data is driven on accept; ack follows one cycle later via sent_q.
      TX_WAIT: begin
        if (!sent_q && !dav_s) begin
          if (tx_valid) begin
            dout_d   = tx_data;
            oe_d     = 1'b1;
            status_d = tx_eoi ? ST_EOI : ST_OK;
            sent_d   = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            dout_d   = 8'h00;
            oe_d     = 1'b1;
            status_d = ST_TIMEOUT;
            sent_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      TX_ACK:  if (dav_s) oe_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!_reset) begin
      sync_q   <= '1;
      code_q   <= '0;
      pay_q    <= '0;
      pend_q   <= 1'b0;
      sent_q   <= 1'b0;
      tmo_q    <= '0;
      dout_q   <= '0;
      oe_q     <= 1'b0;
      status_q <= ST_OK;
      h_ack_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      code_q   <= code_d;
      pay_q    <= pay_d;
      pend_q   <= pend_d;
      sent_q   <= sent_d;
      tmo_q    <= tmo_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      status_q <= status_d;
      h_ack_q  <= h_ack_d;
      err_q    <= err_d;
    end
  end

  assign h_data_out = dout_q;
  assign h_data_oe  = oe_q;
  assign h_status   = status_q;
  assign h_ack      = h_ack_q;
  assign err_pulse  = err_q;

endmodule

// File: tb/tb_tcbm_link.sv
// Scoreboard bench for tcbm_link: directed host transfers, expected rx entries and tx bytes queued at issue time.
module tb_tcbm_link;
  import tcbm_pkg::*;

  logic       clock = 1'b0;
  logic       _reset;
  logic [7:0] h_data_in, h_data_out, rx_data, tx_data;
  logic       h_data_oe, h_dav, h_ack, rx_valid, rx_ready, tx_valid, tx_ready, tx_eoi, err_pulse;
  logic [1:0] h_status, rx_tag;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [9:0] rx_exp_q[$];
  logic [9:0] tx_exp_q[$];
  logic prev_ack = 1'b1, prev_oe = 1'b0, prev_err = 1'b0;

  tcbm_link dut (
    .clock(clock), ._reset(_reset), .h_data_in(h_data_in), .h_data_out(h_data_out),
    .h_data_oe(h_data_oe), .h_dav(h_dav), .h_ack(h_ack), .h_status(h_status),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_tag(rx_tag),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_eoi(tx_eoi),
    .err_pulse(err_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: rx pops, tx byte at the ack falling edge, and err pulses.
  always @(negedge clock) begin
    if (_reset) begin
      if (rx_valid && rx_ready) begin
        chk("rx_pending", 32'(rx_exp_q.size() > 0), 32'd1);
        if (rx_exp_q.size() > 0) chk("rx_entry", 32'({rx_tag, rx_data}), 32'(rx_exp_q.pop_front()));
      end
      if (prev_ack && !h_ack && h_data_oe) begin
        chk("tx_pending", 32'(tx_exp_q.size() > 0), 32'd1);
        if (tx_exp_q.size() > 0) chk("tx_byte", 32'({h_status, h_data_out}), 32'(tx_exp_q.pop_front()));
        chk("tx_data_lead", 32'(prev_oe), 32'd1);
      end
      if (err_pulse) begin
        err_seen++;
        chk("err_width", 32'(prev_err), 32'd0);
      end
    end
    prev_ack <= h_ack;
    prev_oe  <= h_data_oe;
    prev_err <= err_pulse;
  end

  task automatic drive_step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_ack(input logic lvl, input int limit, output int n);
    n = 0;
    while (h_ack !== lvl && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic host_byte(input logic [7:0] b);
    int n;
    drive_step();
    h_data_in = b;
    h_dav = 1'b0;
    wait_ack(1'b0, 50, n);
    chk("ack_low", 32'(h_ack), 32'd0);
    drive_step();
    h_dav = 1'b1;
    wait_ack(1'b1, 50, n);
    chk("ack_high", 32'(h_ack), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    _reset = 1'b0; h_dav = 1'b1; h_data_in = 8'h00; rx_ready = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_eoi = 1'b0;
    repeat (3) drive_step();
    chk("rst_ack", 32'(h_ack), 32'd1);
    chk("rst_oe", 32'(h_data_oe), 32'd0);
    chk("rst_dout", 32'(h_data_out), 32'h00);
    chk("rst_status", 32'(h_status), 32'(ST_OK));
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    _reset = 1'b1;
    repeat (2) drive_step();

    // Command $81 then payload $28, latency from DAV low to rx_valid.
    rx_exp_q.push_back({TAG_CMD, 8'h28});
    host_byte(8'h81);
    drive_step();
    h_data_in = 8'h28;
    h_dav = 1'b0;
    n = 0;
    while (!rx_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("rx_latency_le4", 32'(n <= 4), 32'd1);
    wait_ack(1'b0, 50, n);
    chk("rx_ack_low", 32'(h_ack), 32'd0);
    drive_step();
    rx_ready = 1'b1;
    h_dav = 1'b1;
    wait_ack(1'b1, 50, n);
    chk("rx_ack_high", 32'(h_ack), 32'd1);

    // Talk with EOI byte $41.
    tx_data = 8'h41; tx_eoi = 1'b1; tx_valid = 1'b1;
    tx_exp_q.push_back({ST_EOI, 8'h41});
    host_byte(8'h83);
    chk("tx_ready_dav_high", 32'(tx_ready), 32'd0);
    drive_step();
    h_dav = 1'b0;
    wait_ack(1'b0, 50, n);
    chk("tx_ack_low", 32'(h_ack), 32'd0);
    drive_step();
    tx_valid = 1'b0;
    h_dav = 1'b1;
    wait_ack(1'b1, 50, n);
    chk("oe_drop_with_ack", 32'(h_data_oe), 32'd0);
    chk("eoi_status_hold", 32'(h_status), 32'(ST_EOI));

    // Talk with no tx byte offered: timeout status.
    tx_exp_q.push_back({ST_TIMEOUT, 8'h00});
    host_byte(8'h83);
    drive_step();
    h_dav = 1'b0;
    wait_ack(1'b0, 1200, n);
    chk("timeout_window", 32'(n >= 1025 && n <= 1031), 32'd1);
    chk("timeout_status", 32'(h_status), 32'(ST_TIMEOUT));
    chk("timeout_dout", 32'(h_data_out), 32'h00);
    drive_step();
    h_dav = 1'b1;
    wait_ack(1'b1, 50, n);
    chk("timeout_release", 32'(h_ack), 32'd1);

    // Five data payloads with no consumer: the fifth ack stalls until the first pop.
    drive_step();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) rx_exp_q.push_back({TAG_DATA, 8'(8'hA0 + i)});
    for (int i = 0; i < 4; i++) begin
      host_byte(8'h82);
      host_byte(8'(8'hA0 + i));
    end
    host_byte(8'h82);
    drive_step();
    h_data_in = 8'hA4;
    h_dav = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("fifth_stalled", 32'(h_ack), 32'd1);
    drive_step();
    rx_ready = 1'b1;
    wait_ack(1'b0, 10, n);
    chk("stall_release_cycles", 32'(n), 32'd2);
    drive_step();
    h_dav = 1'b1;
    wait_ack(1'b1, 50, n);
    chk("stall_ack_high", 32'(h_ack), 32'd1);
    repeat (10) drive_step();

    // Invalid code $90.
    rx_ready = 1'b0;
    host_byte(8'h90);
    repeat (4) drive_step();
    chk("err_once", 32'(err_seen), 32'd1);
    chk("invalid_no_write", 32'(rx_valid), 32'd0);

    // Reset while in TX_ACK, then a normal command transfer.
    tx_data = 8'h55; tx_eoi = 1'b0; tx_valid = 1'b1;
    tx_exp_q.push_back({ST_OK, 8'h55});
    host_byte(8'h83);
    drive_step();
    h_dav = 1'b0;
    wait_ack(1'b0, 50, n);
    chk("pre_reset_ack_low", 32'(h_ack), 32'd0);
    drive_step();
    _reset = 1'b0;
    tx_valid = 1'b0;
    drive_step();
    chk("mid_rst_ack", 32'(h_ack), 32'd1);
    chk("mid_rst_oe", 32'(h_data_oe), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
    h_dav = 1'b1;
    _reset = 1'b1;
    rx_ready = 1'b1;
    rx_exp_q.push_back({TAG_CMD, 8'h10});
    repeat (2) drive_step();
    host_byte(8'h81);
    host_byte(8'h10);

    repeat (10) drive_step();
    chk("rx_drained", 32'(rx_exp_q.size()), 32'd0);
    chk("tx_drained", 32'(tx_exp_q.size()), 32'd0);
    chk("err_total", 32'(err_seen), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcbm_link.md
TCBM_LINK -- requirements
Module: tcbm_link

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on h_dav.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum wait for tx byte before timeout status.
REQ-003 SHALL have parameter RX_DEPTH, default 4: rx FIFO entries, power of two.
REQ-004 SHALL have port clock, input, 1: single clock.
REQ-005 SHALL have port _reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port h_data_in, input, 8: TIA port A pins, read side.
REQ-007 SHALL have port h_data_out, output, 8: byte driven to port A.
REQ-008 SHALL have port h_data_oe, output, 1: port A drive enable.
REQ-009 SHALL have port h_dav, input, 1: host DAV (port C bit 7), idle high.
REQ-010 SHALL have port h_ack, output, 1: device ACK (port C bit 6), idle high.
REQ-011 SHALL have port h_status, output, 2: port B status, where 00 = ok, 10 = EOI, 01 = timeout.
REQ-012 SHALL have the rx stream ports rx_valid (output, 1), rx_ready (input, 1), rx_data (output, 8) and rx_tag (output, 2), with tags 01 = command, 10 = data, 11 = secondary.
REQ-013 SHALL have the tx stream ports tx_valid (input, 1), tx_ready (output, 1), tx_data (input, 8) and tx_eoi (input, 1).
REQ-014 SHALL have port err_pulse, output, 1: one-cycle flag on an invalid code byte.

Function
REQ-015 SHALL pass h_dav through SYNC_STAGES flops; all handshake decisions SHALL use the synced value dav_s.
REQ-016 SHALL sample h_data_in in the cycle dav_s is first seen low.
REQ-017 SHALL implement FSM states IDLE, CODE_ACK, CODE_REL, PAY_WAIT, RX_ACK, RX_REL, TX_WAIT, TX_ACK, TX_REL.
REQ-018 In IDLE, on dav_s low, SHALL latch the code byte and drive h_ack low on the next cycle (CODE_ACK).
REQ-019 Code bytes: $81 -> tag 01, $82 -> tag 10, $84 -> tag 11, $83 -> device-to-host transfer.
REQ-020 Any other code byte SHALL be acknowledged normally, pulse err_pulse once and return to IDLE after release.
REQ-021 CODE_ACK -> CODE_REL on dav_s high; the device SHALL then drive h_ack high and go to PAY_WAIT (rx codes) or TX_WAIT ($83).
REQ-022 PAY_WAIT, on dav_s low: SHALL latch the payload and write {tag, byte} into the FIFO, then go to RX_ACK.
REQ-023 If the FIFO is full, the device SHALL hold h_ack high and stall until an entry is free, then write and ack; no byte SHALL be dropped.
REQ-024 RX_ACK: h_ack low until dav_s high, then h_ack high and return to IDLE (RX_REL).
REQ-025 TX_WAIT, on dav_s low: tx_ready SHALL be 1; on tx_valid & tx_ready, drive h_data_out = tx_data, h_data_oe = 1 and h_status = tx_eoi ? 10 : 00.
REQ-026 In the TX_WAIT accept cycle, h_ack SHALL go low one cycle after data is driven (TX_ACK).
REQ-027 Timeout: if no tx_valid within TIMEOUT_CYCLES after dav_s low, the device SHALL drive h_data_out = $00 and h_status = 01, then ack.
REQ-028 TX_ACK -> TX_REL on dav_s high: h_data_oe SHALL drop the same cycle as h_ack goes high; h_status SHALL hold until the next transfer.
REQ-029 tx_ready SHALL be 1 only in TX_WAIT with dav_s low.
REQ-030 rx_valid SHALL be high whenever the FIFO is not empty; a pop occurs on rx_valid & rx_ready.
REQ-031 A push and a pop in the same cycle SHALL both succeed when the FIFO is full.
REQ-032 FIFO pointers SHALL be log2(RX_DEPTH)+1 bits wide and wrap modulo 2*RX_DEPTH.

Reset
REQ-033 _reset low at a clock edge SHALL set: FSM IDLE, h_ack = 1, h_data_oe = 0, h_data_out = $00, h_status = 00, FIFO empty (rx_valid = 0), tx_ready = 0, err_pulse = 0, synchronizer flops = 1.
REQ-034 Reset mid-transfer SHALL release the bus in the same edge; any partial byte SHALL be discarded.

Structure
REQ-035 A shared package tcbm_pkg SHALL hold: code constants $81–$84, tag encodings, status encodings and the FSM state enum.
REQ-036 The rx FIFO SHALL be one sub-module, tcbm_rx_fifo (parameter DEPTH, width 10).

Verification
REQ-037 Host sends $81 then $28 -> ack toggles twice; rx_data = $28 and rx_tag = 01 appear within 4 cycles of DAV low.
REQ-038 Host sends $83 with tx_data = $41, tx_eoi = 1 -> h_data_out = $41, h_status = 10, oe drops when DAV rises.
REQ-039 Host sends $83 with tx_valid never asserted -> after 1024 cycles, h_data_out = $00 and h_status = 01.
REQ-040 With rx_ready = 0, five $82 payloads -> the fifth ack is stalled; it completes one cycle after the first pop, data order is preserved.
REQ-041 Host sends code $90 -> err_pulse for 1 cycle, ack completes, no FIFO write.
REQ-042 _reset asserted in TX_ACK -> the next edge gives h_ack = 1, oe = 0, IDLE, and a following $81/$10 transfer works.
